// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing a shared-memory, single-ALU CPU datapath.
// Optional build macro MEM_WAIT_EN adds the mem_ready port and memory wait states.
`default_nettype none

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_en,
  output logic       iord,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t cur;
  logic   hold;
  logic   pc_wr;
  logic   pc_wr_cond;

  wire is_rtype = (op == OP_RTYPE);
  wire is_j     = (op == OP_J);
  wire is_beq   = (op == OP_BEQ);
  wire is_addiu = (op == OP_ADDIU);
  wire is_ori   = (op == OP_ORI);
  wire is_lw    = (op == OP_LW);
  wire is_sw    = (op == OP_SW);

`ifdef MEM_WAIT_EN
  assign hold = !mem_ready && (cur == FETCH || cur == MEMRD || cur == MEMWR);
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= FETCH;
    end else if (!hold) begin
      case (cur)
        FETCH:  cur <= DECODE;
        DECODE: begin
          if (is_lw || is_sw)          cur <= MEMADR;
          else if (is_rtype)           cur <= EXEC;
          else if (is_beq)             cur <= BRANCH;
          else if (is_ori || is_addiu) cur <= IEXEC;
          else if (is_j)               cur <= JUMP;
          else                         cur <= FETCH;
        end
        MEMADR: cur <= is_sw ? MEMWR : MEMRD;
        MEMRD:  cur <= MEMWB;
        EXEC:   cur <= ALUWB;
        IEXEC:  cur <= IWB;
        default: cur <= FETCH;
      endcase
    end
  end

  // Gating on rst keeps every strobe low for the whole reset window, not just after the edge.
  always_comb begin
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    ext_op     = 1'b0;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (cur)
        FETCH: begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          alu_src_b = 2'b01;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
          if (!(is_lw || is_sw || is_rtype || is_beq || is_ori || is_addiu || is_j)) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
        end
        MEMRD: iord = 1'b1;
        MEMWB: begin
          reg_wr     = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          iord       = 1'b1;
          mem_wr     = 1'b1;
          instr_done = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b001;
        end
        ALUWB: begin
          reg_wr     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 3'b100;
          pc_src     = 2'b01;
          pc_wr_cond = 1'b1;
          instr_done = 1'b1;
        end
        IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (is_ori) alu_op = 3'b010;
          else        ext_op = 1'b1;
        end
        IWB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_src     = 2'b10;
          pc_wr      = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
      // A held memory state keeps its selects but must not commit anything.
      if (hold) begin
        ir_wr      = 1'b0;
        mem_wr     = 1'b0;
        pc_wr      = 1'b0;
        instr_done = 1'b0;
      end
    end
  end

  assign pc_en = pc_wr | (pc_wr_cond & zero);
  assign state = cur;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for a multicycle build of the CPU. It supports the same instruction subset as the pipeline core: R-type, ori, addiu, lw, sw, beq and j. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback, driving every enable and mux select. Opcode decoding happens inside the FSM; the datapath supplies only the opcode field and the ALU zero flag.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op  in  6  IR[31:26]; must be stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory handshake; port exists only with MEM_WAIT_EN
- pc_en  out  1  PC write enable; equals pc_wr | (pc_wr_cond & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_wr  out  1  memory write strobe
- ir_wr  out  1  IR load enable
- reg_wr  out  1  register file write enable
- reg_dst  out  1  write register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback data select: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B reg, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- alu_op  out  3  ALU op: 000 add, 001 funct-decode, 010 or, 100 sub
- ext_op  out  1  immediate extension: 1 = sign, 0 = zero
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE when op is unrecognised
- state  out  4  current state, for debug only

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge with all outputs 0.
- Every output not listed for a state is 0.
- FETCH: ir_wr=1, pc_wr=1, alu_src_b=01, alu_op=000. Next state DECODE.
- DECODE: alu_src_b=11, ext_op=1; precomputes the branch target. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - ori/addiu → IEXEC
  - j → JUMP
  - any other op → FETCH, with illegal=1 and instr_done=1
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=000. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state MEMWB.
- MEMWB: reg_wr=1, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEMWR: iord=1, mem_wr=1, instr_done=1. Next state FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=001. Next state ALUWB.
- ALUWB: reg_wr=1, reg_dst=1, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_src=01, pc_wr_cond=1, instr_done=1. Next state FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10.
  - ori: alu_op=010, ext_op=0
  - addiu: alu_op=000, ext_op=1
  - Next state IWB.
- IWB: reg_wr=1, instr_done=1. Next state FETCH.
- JUMP: pc_src=10, pc_wr=1, instr_done=1. Next state FETCH.
- All outputs are decoded combinationally from the state register and op. pc_en also depends on zero.

## Timing
- Reset: an asynchronous assert forces state=FETCH. While rst=1, every enable and pulse is 0: pc_en, ir_wr, mem_wr, reg_wr, instr_done, illegal. All selects are also 0.
- The first FETCH executes on the first rising edge after rst deasserts.
- Reset mid-instruction abandons the instruction. No partial write may occur after rst rises.
- Cycles per instruction (no wait states): lw 5; sw, R-type, ori, addiu 4; beq, j 3; illegal op 2.
- beq: pc_en in BRANCH equals zero within the same cycle. No extra cycle is spent when the branch is taken.
- instr_done rises exactly once per instruction, including illegal ones.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold while mem_ready=0.
  - During a hold, ir_wr, pc_en and mem_wr are forced to 0. Selects (iord, alu_src_*, alu_op) stay at their state values.
  - The state's strobes fire and the transition occurs in the first cycle with mem_ready=1.
  - mem_ready is ignored in all other states.
  - A wait of N cycles adds N to the CPI.
- MEM_WAIT_EN undefined: the mem_ready port is absent and every state lasts exactly one cycle.

## Test plan
- Reset with rst=1 for 3 cycles, release, drive op=100011 (lw) → state sequence 0,1,2,3,4,0; reg_wr=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
- op=000100 (beq) run twice, zero=1 then zero=0 → pc_en=1 in BRANCH the first time and 0 the second; each instruction takes 3 cycles.
- op=001101 (ori) then op=001001 (addiu) → in IEXEC, alu_op=010/ext_op=0 then alu_op=000/ext_op=1; reg_dst=0 in IWB for both.
- op=111111 → illegal=1 and instr_done=1 in DECODE; returns to FETCH after 2 cycles; no write enable ever asserts.
- Assert rst asynchronously mid-cycle during MEMWR → mem_wr drops to 0 immediately and state=0.
- With MEM_WAIT_EN, op=101011 (sw) and mem_ready held 0 for 2 cycles in MEMWR → mem_wr=0 during the wait, mem_wr=1 on the ready cycle, CPI=6.
